// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_pkg : shared processor constants, IF-stage state encoding    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fetch_stage_pkg;

  typedef logic [15:0] word_t;

  localparam word_t FS_RESET_PC  = 16'h0000;
  localparam word_t FS_NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_DROP   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  function automatic word_t pc_inc(input word_t pc);
    return pc + 16'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_if : control, instruction-memory and IF/ID signals of fetch  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  stall_fd;
  logic  redirect;
  word_t redirect_pc;
  logic  halt_dec;
  word_t mem_rdata;
  logic  mem_done;
  logic  mem_rd;
  word_t mem_addr;
  logic  fd_en;
  word_t instruction;
  word_t currPC;
  word_t pc_plus_2;
  logic  err;

  modport master (
    input  stall_fd, redirect, redirect_pc, halt_dec, mem_rdata, mem_done,
    output mem_rd, mem_addr, fd_en, instruction, currPC, pc_plus_2, err
  );

  modport slave (
    output stall_fd, redirect, redirect_pc, halt_dec, mem_rdata, mem_done,
    input  mem_rd, mem_addr, fd_en, instruction, currPC, pc_plus_2, err
  );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_pc_reg : enabled program-counter register, async low reset   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_stage_pc_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : instruction fetch FSM, stall buffer and IF/ID output mux   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = FS_RESET_PC,
  parameter word_t NOP_INSTR = FS_NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  word_t        w_pc;
  word_t        w_pc_d;
  word_t        w_redir_pc;
  word_t        w_instr;
  word_t        w_curr_pc;
  word_t        r_buf;
  word_t        r_drop_addr;
  word_t        r_curr_pc;
  logic         w_pc_en;
  logic         w_present;
  logic         w_capture;
  logic         w_mem_rd;
  logic         w_valid;
  logic         w_redir_ok;
  logic         r_err;

  assign w_redir_pc = {bus.redirect_pc[15:1], 1'b0};
  assign w_redir_ok = bus.redirect && (r_state != ST_HALTED);

  fetch_stage_pc_reg #(
    .WIDTH    (16),
    .RESET_VAL(RESET_PC)
  ) pc_reg (
    .clk (clk),
    .rst (rst),
    .i_en(w_pc_en),
    .i_d (w_pc_d),
    .o_q (w_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_present   = 1'b0;
    w_capture   = 1'b0;
    w_mem_rd    = 1'b0;
    w_instr     = NOP_INSTR;
    case (r_state)
      ST_FETCH, ST_WAIT: begin
        w_mem_rd = 1'b1;
        w_instr  = bus.mem_rdata;
        if (bus.redirect) begin
          w_state_nxt = (r_state == ST_WAIT && !bus.mem_done) ? ST_DROP : ST_FETCH;
        end else begin
          w_present = bus.mem_done && !bus.stall_fd;
          w_capture = bus.mem_done && bus.stall_fd;
          if (bus.halt_dec) begin
            w_state_nxt = ST_HALTED;
          end else if (bus.mem_done) begin
            w_state_nxt = bus.stall_fd ? ST_HOLD : ST_FETCH;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_HOLD: begin
        w_instr = r_buf;
        if (bus.redirect) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_present = !bus.stall_fd;
          if (bus.halt_dec) begin
            w_state_nxt = ST_HALTED;
          end else if (!bus.stall_fd) begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_DROP: begin
        // Old request must still complete; redirects here only retarget the PC.
        w_mem_rd = 1'b1;
        if (bus.halt_dec && !bus.redirect) begin
          w_state_nxt = ST_HALTED;
        end else if (bus.mem_done) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  assign w_pc_en = w_redir_ok || w_present;
  assign w_pc_d  = w_redir_ok ? w_redir_pc : pc_inc(w_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_FETCH;
      r_buf       <= '0;
      r_drop_addr <= RESET_PC;
      r_curr_pc   <= RESET_PC;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_redir_ok && bus.redirect_pc[0];
      if (w_capture) begin
        r_buf <= bus.mem_rdata;
      end
      if (w_state_nxt == ST_DROP && r_state != ST_DROP) begin
        r_drop_addr <= w_pc;
      end
      if (w_present) begin
        r_curr_pc <= w_pc;
      end
    end
  end

  // Outputs are gated by rst so nothing leaks while the async reset is held.
  assign w_valid         = rst && w_present;
  assign w_curr_pc       = w_valid ? w_pc : r_curr_pc;
  assign bus.mem_rd      = rst && w_mem_rd;
  assign bus.mem_addr    = (r_state == ST_DROP) ? r_drop_addr : w_pc;
  assign bus.fd_en       = !bus.stall_fd;
  assign bus.instruction = w_valid ? w_instr : NOP_INSTR;
  assign bus.currPC      = w_curr_pc;
  assign bus.pc_plus_2   = pc_inc(w_curr_pc);
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : vector table plus hand sequences, scoreboard of words   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word_t NOP = 16'h0800;

  typedef struct {
    logic  stall;
    logic  redir;
    word_t rpc;
    logic  halt;
    word_t rdata;
    logic  done;
    logic  e_rd;
    word_t e_addr;
    word_t e_instr;
    word_t e_cpc;
    logic  e_err;
  } vec_t;

  logic          clk;
  logic          rst;
  fetch_stage_if bus ();

  vec_t          vecs[$];
  vec_t          v;
  logic [31:0]   sb_q[$];
  logic [31:0]   sb_e;
  int            n_checks = 0;
  int            n_pass   = 0;

  fetch_stage #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic st, input logic rdr, input word_t rpc, input logic hlt,
                     input word_t rdata, input logic dn, input logic erd, input word_t eaddr,
                     input word_t einstr, input word_t ecpc, input logic eerr);
    vec_t t;
    t = '{st, rdr, rpc, hlt, rdata, dn, erd, eaddr, einstr, ecpc, eerr};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic st, input logic rdr, input word_t rpc, input logic hlt,
                       input word_t rdata, input logic dn, input word_t einstr, input word_t ecpc);
    bus.stall_fd    = st;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    bus.halt_dec    = hlt;
    bus.mem_rdata   = rdata;
    bus.mem_done    = dn;
    if (einstr != NOP) sb_q.push_back({einstr, ecpc});
  endtask

  task automatic check_row(input string tag, input logic erd, input word_t eaddr,
                           input word_t einstr, input word_t ecpc, input logic eerr);
    word_t w_exp_p2;
    w_exp_p2 = ecpc + 16'd2;
    chk({tag, ".mem_rd"}, {15'd0, bus.mem_rd}, {15'd0, erd});
    if (erd) chk({tag, ".mem_addr"}, bus.mem_addr, eaddr);
    chk({tag, ".instr"}, bus.instruction, einstr);
    chk({tag, ".currPC"}, bus.currPC, ecpc);
    chk({tag, ".pc_plus_2"}, bus.pc_plus_2, w_exp_p2);
    chk({tag, ".err"}, {15'd0, bus.err}, {15'd0, eerr});
    chk({tag, ".fd_en"}, {15'd0, bus.fd_en}, {15'd0, !bus.stall_fd});
  endtask

  // Every non-bubble word the DUT presents must match the next queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.instruction !== NOP) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_extra: got %h at pc %h expected no word", bus.instruction, bus.currPC);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb.instr", bus.instruction, sb_e[31:16]);
        chk("sb.pc", bus.currPC, sb_e[15:0]);
      end
    end
  end

  initial begin
    //  st rdr rpc       hlt rdata     dn | rd addr      instr     cpc       err
    add(0, 0, 16'h0000, 0, 16'h4101, 1,   1, 16'h0000, 16'h4101, 16'h0000, 0);
    add(0, 0, 16'h0000, 0, 16'h4202, 1,   1, 16'h0002, 16'h4202, 16'h0002, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0004, NOP,      16'h0002, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0004, NOP,      16'h0002, 0);
    add(0, 0, 16'h0000, 0, 16'h4303, 1,   1, 16'h0004, 16'h4303, 16'h0004, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0006, NOP,      16'h0004, 0);
    add(1, 0, 16'h0000, 0, 16'h4404, 1,   1, 16'h0006, NOP,      16'h0004, 0);
    add(1, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0006, NOP,      16'h0004, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0006, 16'h4404, 16'h0006, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0008, NOP,      16'h0006, 0);
    add(0, 1, 16'h0040, 0, 16'h0000, 0,   1, 16'h0008, NOP,      16'h0006, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0008, NOP,      16'h0006, 0);
    add(0, 0, 16'h0000, 0, 16'hDEAD, 1,   1, 16'h0008, NOP,      16'h0006, 0);
    add(0, 0, 16'h0000, 0, 16'h4505, 1,   1, 16'h0040, 16'h4505, 16'h0040, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0042, NOP,      16'h0040, 0);
    add(0, 1, 16'h0080, 0, 16'h0000, 0,   1, 16'h0042, NOP,      16'h0040, 0);
    add(0, 1, 16'h0100, 0, 16'h0000, 0,   1, 16'h0042, NOP,      16'h0040, 0);
    add(0, 0, 16'h0000, 0, 16'hBEEF, 1,   1, 16'h0042, NOP,      16'h0040, 0);
    add(0, 0, 16'h0000, 0, 16'h4606, 1,   1, 16'h0100, 16'h4606, 16'h0100, 0);
    add(0, 1, 16'h0033, 0, 16'h4707, 1,   1, 16'h0102, NOP,      16'h0100, 0);
    add(0, 0, 16'h0000, 0, 16'h4808, 1,   1, 16'h0032, 16'h4808, 16'h0032, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h0034, NOP,      16'h0032, 0);
    add(0, 1, 16'hFFFE, 0, 16'hDEAD, 1,   1, 16'h0034, NOP,      16'h0032, 0);
    add(0, 0, 16'h0000, 0, 16'h4909, 1,   1, 16'hFFFE, 16'h4909, 16'hFFFE, 0);
    add(0, 0, 16'h0000, 0, 16'h4A0A, 1,   1, 16'h0000, 16'h4A0A, 16'h0000, 0);
    add(1, 0, 16'h0000, 0, 16'h4B0B, 1,   1, 16'h0002, NOP,      16'h0000, 0);
    add(1, 1, 16'h0200, 0, 16'h0000, 0,   0, 16'h0002, NOP,      16'h0000, 0);
    add(0, 0, 16'h0000, 0, 16'h4C0C, 1,   1, 16'h0200, 16'h4C0C, 16'h0200, 0);

    // Reset held with a stray mem_done present.
    rst = 1'b0;
    drive(0, 0, 16'h0000, 0, 16'h1234, 1, NOP, 16'h0000);
    #3;
    check_row("rst0", 0, 16'h0000, NOP, 16'h0000, 0);
    @(posedge clk); #1;
    check_row("rst1", 0, 16'h0000, NOP, 16'h0000, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      v = vecs[i];
      drive(v.stall, v.redir, v.rpc, v.halt, v.rdata, v.done, v.e_instr, v.e_cpc);
      #2;
      check_row($sformatf("v%0d", i), v.e_rd, v.e_addr, v.e_instr, v.e_cpc, v.e_err);
    end

    // Halt, then a redirect that must be ignored.
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 1, 16'h0000, 0, NOP, 16'h0000);
    #2;
    check_row("halt0", 1, 16'h0202, NOP, 16'h0200, 0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      drive(0, (k == 10), 16'h0301, 0, 16'h0000, 0, NOP, 16'h0000);
      #2;
      check_row($sformatf("halted%0d", k), 0, 16'h0000, NOP, 16'h0200, 0);
    end

    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0000);
    #2;
    check_row("halt_rst", 0, 16'h0000, NOP, 16'h0000, 0);

    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 16'h0000, 0, 16'h4E0E, 1, 16'h4E0E, 16'h0000);
    #2;
    check_row("post0", 1, 16'h0000, 16'h4E0E, 16'h0000, 0);
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 16'h4F0F, 1, 16'h4F0F, 16'h0002);
    #2;
    check_row("post1", 1, 16'h0002, 16'h4F0F, 16'h0002, 0);
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0000);
    #2;
    check_row("post2", 1, 16'h0004, NOP, 16'h0002, 0);

    // Reset lands in the middle of an outstanding request.
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0000);
    #1;
    rst = 1'b0;
    #1;
    check_row("rst_mid", 0, 16'h0000, NOP, 16'h0000, 0);
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 16'hDEAD, 1, NOP, 16'h0000);
    #2;
    check_row("rst_stale", 0, 16'h0000, NOP, 16'h0000, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0000);
    #2;
    check_row("restart0", 1, 16'h0000, NOP, 16'h0000, 0);
    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 16'h5010, 1, 16'h5010, 16'h0000);
    #2;
    check_row("restart1", 1, 16'h0000, 16'h5010, 16'h0000, 0);

    @(posedge clk); #1;
    drive(0, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0000);
    #6;
    chk("sb.empty", word_t'(sb_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
